// File: rtl/crossbar_pkg.sv
// crossbar_pkg
// Shared definitions for the crossbar slave-side blocks: bus widths,
// command encoding, the error read-back pattern and the slave FSM states.
// No ports (package).
package crossbar_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Returned on a read that falls outside the populated word array.
    localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } slave_state_e;

endpackage : crossbar_pkg

// File: rtl/crossbar_slave_mem_if.sv
// crossbar_slave_mem_if
// Bus bundle between a crossbar slave port and the memory responder.
//   req, cmd, addr, wdata : request side, driven by the crossbar (master)
//   ack, rdata, busy      : response side, driven by the responder (slave)
//   err                   : out-of-range flag, only with CROSSBAR_SLAVE_MEM_ERR_EN
interface crossbar_slave_mem_if;
    import crossbar_pkg::*;

    logic              req;
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
    logic              err;

    modport master (output req, cmd, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, cmd, addr, wdata, output ack, rdata, busy, err);
`else
    modport master (output req, cmd, addr, wdata, input ack, rdata, busy);
    modport slave  (input req, cmd, addr, wdata, output ack, rdata, busy);
`endif

endinterface : crossbar_slave_mem_if

// File: rtl/crossbar_slave_mem_array.sv
// crossbar_slave_mem_array
// 2**DEPTH_LOG2 x DATA_W register file with one synchronous write port and
// one combinational read port. Asynchronous reset clears every word.
//   clk, rst     : clock, asynchronous active-high reset
//   we           : write enable
//   waddr, wdata : write word index and data
//   raddr, rdata : read word index and combinational data
module crossbar_slave_mem_array
    import crossbar_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Word storage: cleared on reset, one word written per enabled edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : crossbar_slave_mem_array

// File: rtl/crossbar_slave_mem.sv
// crossbar_slave_mem
// Scratch-RAM responder terminating one crossbar slave port. A request seen
// in IDLE is captured, held for LATENCY wait cycles, then performed against
// the internal word array; ack pulses one cycle later with rdata valid.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : crossbar_slave_mem_if.slave (req/cmd/addr/wdata in,
//          ack/rdata/busy out, err out with CROSSBAR_SLAVE_MEM_ERR_EN)
// Parameters: DEPTH_LOG2 (1..8) word-count log2, LATENCY (0..15) wait cycles.
// Optional feature macro: CROSSBAR_SLAVE_MEM_ERR_EN enables the range check
// on addr[30:DEPTH_LOG2]; without it upper address bits alias.
module crossbar_slave_mem
    import crossbar_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    crossbar_slave_mem_if.slave bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_ACK  = ST_ACK;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]            state_r;
    logic [1:0]            state_nx_s;
    logic [3:0]            cnt_r;
    logic                  cmd_r;
    logic [DEPTH_LOG2-1:0] idx_r;
    logic [DATA_W-1:0]     wdata_r;
    logic                  oor_r;
    logic                  ack_r;
    logic                  err_r;
    logic                  busy_r;
    logic [DATA_W-1:0]     rdata_r;

    logic                  live_oor_s;
    logic                  use_live_s;
    logic                  cur_cmd_s;
    logic [DEPTH_LOG2-1:0] cur_idx_s;
    logic [DATA_W-1:0]     cur_wdata_s;
    logic                  cur_oor_s;
    logic                  enter_ack_s;
    logic                  mem_we_s;
    logic [DATA_W-1:0]     mem_rdata_s;
    logic                  addr_unused_s;

`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
    assign live_oor_s    = (bus.addr[ADDR_W-2:DEPTH_LOG2] != {(ADDR_W-1-DEPTH_LOG2){1'b0}});
    assign addr_unused_s = bus.addr[ADDR_W-1];
    assign bus.err       = err_r;
`else
    assign live_oor_s    = 1'b0;
    assign addr_unused_s = ^{bus.addr[ADDR_W-1:DEPTH_LOG2], err_r};
`endif

    // With LATENCY=0 the array is accessed on the capture edge itself, before
    // the capture registers hold the request, so the live inputs are used then.
    assign use_live_s  = (state_r == S_IDLE);
    assign cur_cmd_s   = use_live_s ? bus.cmd                    : cmd_r;
    assign cur_idx_s   = use_live_s ? bus.addr[DEPTH_LOG2-1:0]   : idx_r;
    assign cur_wdata_s = use_live_s ? bus.wdata                  : wdata_r;
    assign cur_oor_s   = use_live_s ? live_oor_s                 : oor_r;

    assign enter_ack_s = (state_nx_s == S_ACK);
    assign mem_we_s    = enter_ack_s && (cur_cmd_s == CMD_WRITE) && !cur_oor_s;

    crossbar_slave_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .waddr (cur_idx_s),
        .wdata (cur_wdata_s),
        .raddr (cur_idx_s),
        .rdata (mem_rdata_s)
    );

    // Next-state decode for the request FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.req) begin
                    state_nx_s = (LATENCY > 0) ? S_WAIT : S_ACK;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = S_ACK;
                end else begin
                    state_nx_s = S_WAIT;
                end
            end
            S_ACK: begin
                state_nx_s = S_DONE;
            end
            S_DONE: begin
                // A held req must not re-trigger; wait for it to drop.
                if (!bus.req) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // FSM state, latency counter and request capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
            cmd_r   <= CMD_READ;
            idx_r   <= {DEPTH_LOG2{1'b0}};
            wdata_r <= 32'h0000_0000;
            oor_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                S_IDLE: begin
                    if (bus.req) begin
                        cnt_r   <= LAT_INIT;
                        cmd_r   <= bus.cmd;
                        idx_r   <= bus.addr[DEPTH_LOG2-1:0];
                        wdata_r <= bus.wdata;
                        oor_r   <= live_oor_s;
                    end
                end
                S_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered response outputs; ack/err follow the ACK state by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ack_r  <= (state_r == S_ACK);
            err_r  <= (state_r == S_ACK) && oor_r;
            busy_r <= (state_nx_s != S_IDLE);
            if (enter_ack_s && (cur_cmd_s == CMD_READ)) begin
                rdata_r <= cur_oor_s ? ERR_RDATA : mem_rdata_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.ack   = ack_r;
    assign bus.busy  = busy_r;
    assign bus.rdata = rdata_r;

endmodule : crossbar_slave_mem

// File: tb/tb_crossbar_slave_mem.sv
// tb_crossbar_slave_mem
// Directed bench: two responders (LATENCY=2 and LATENCY=0, DEPTH_LOG2=4)
// share the same request stimulus; each test task compares their responses
// against hand-computed values.
module tb_crossbar_slave_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        cmd;
    logic [31:0] addr;
    logic [31:0] wdata;

    int tests_run    = 0;
    int tests_failed = 0;

    int          lat0, lat2, acks0, acks2;
    logic [31:0] rd0, rd2;
    logic        err0, err2;

`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    crossbar_slave_mem_if bus0();
    crossbar_slave_mem_if bus2();

    assign bus0.req   = req;
    assign bus0.cmd   = cmd;
    assign bus0.addr  = addr;
    assign bus0.wdata = wdata;
    assign bus2.req   = req;
    assign bus2.cmd   = cmd;
    assign bus2.addr  = addr;
    assign bus2.wdata = wdata;

    crossbar_slave_mem #(.DEPTH_LOG2(4), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    crossbar_slave_mem #(.DEPTH_LOG2(4), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    always #5 clk = ~clk;

    // Issue one request to both DUTs; sample n counts edges after capture edge E.
    task automatic txn(input logic c, input logic [31:0] a, input logic [31:0] d);
        lat0 = -1; lat2 = -1; acks0 = 0; acks2 = 0;
        rd0 = 32'hxxxx_xxxx; rd2 = 32'hxxxx_xxxx; err0 = 1'b0; err2 = 1'b0;
        req = 1'b1; cmd = c; addr = a; wdata = d;
        @(posedge clk); #1;
        for (int n = 0; n < 30; n++) begin
            if (bus0.ack === 1'b1) begin
                acks0++;
                if (lat0 < 0) begin
                    lat0 = n; rd0 = bus0.rdata;
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
                    err0 = bus0.err;
`endif
                end
            end
            if (bus2.ack === 1'b1) begin
                acks2++;
                if (lat2 < 0) begin
                    lat2 = n; rd2 = bus2.rdata;
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
                    err2 = bus2.err;
`endif
                end
            end
            if (lat0 >= 0 && lat2 >= 0) break;
            @(posedge clk); #1;
        end
        req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus0.ack === 1'b1) acks0++;
            if (bus2.ack === 1'b1) acks2++;
            if (bus0.busy === 1'b0 && bus2.busy === 1'b0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; cmd = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (bus2.ack !== 1'b0) begin tests_failed++; $display("FAIL rst_ack2: got %b expected 0", bus2.ack); end
        tests_run++; if (bus2.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy2: got %b expected 0", bus2.busy); end
        tests_run++; if (bus2.rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata2: got %h expected 00000000", bus2.rdata); end
        tests_run++; if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_dut0: got ack=%b busy=%b expected 0/0", bus0.ack, bus0.busy); end
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
        tests_run++; if (bus2.err !== 1'b0) begin tests_failed++; $display("FAIL rst_err2: got %b expected 0", bus2.err); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency0();
        txn(1'b0, 32'h0000_0000, 32'h0);
        tests_run++; if (lat0 !== 1) begin tests_failed++; $display("FAIL lat0_read: got %0d expected 1", lat0); end
        tests_run++; if (rd0 !== 32'h0) begin tests_failed++; $display("FAIL lat0_rdata: got %h expected 00000000", rd0); end
        tests_run++; if (lat2 !== 3) begin tests_failed++; $display("FAIL lat2_read: got %0d expected 3", lat2); end
    endtask

    task automatic test_write_read();
        txn(1'b1, 32'h0000_0003, 32'h1111_1111);
        tests_run++; if (lat2 !== 3) begin tests_failed++; $display("FAIL wr_lat2: got %0d expected 3", lat2); end
        tests_run++; if (acks2 !== 1 || acks0 !== 1) begin tests_failed++; $display("FAIL wr_ack_pulses: got %0d/%0d expected 1/1", acks2, acks0); end
        txn(1'b0, 32'h0000_0003, 32'h0);
        tests_run++; if (lat2 !== 3 || lat0 !== 1) begin tests_failed++; $display("FAIL rd_lat: got %0d/%0d expected 3/1", lat2, lat0); end
        tests_run++; if (rd2 !== 32'h1111_1111) begin tests_failed++; $display("FAIL rd_data2: got %h expected 11111111", rd2); end
        tests_run++; if (rd0 !== 32'h1111_1111) begin tests_failed++; $display("FAIL rd_data0: got %h expected 11111111", rd0); end
    endtask

    task automatic test_slave_select();
        txn(1'b1, 32'h8000_0005, 32'h2222_2222);
        txn(1'b0, 32'h0000_0005, 32'h0);
        tests_run++; if (rd2 !== 32'h2222_2222) begin tests_failed++; $display("FAIL sel_bit2: got %h expected 22222222", rd2); end
        tests_run++; if (rd0 !== 32'h2222_2222) begin tests_failed++; $display("FAIL sel_bit0: got %h expected 22222222", rd0); end
    endtask

    task automatic test_held_req();
        int busy_lo;
        busy_lo = 0; acks0 = 0; acks2 = 0;
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_0009; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        for (int n = 0; n < 14; n++) begin
            if (bus0.ack === 1'b1) acks0++;
            if (bus2.ack === 1'b1) acks2++;
            if (bus0.busy !== 1'b1 || bus2.busy !== 1'b1) busy_lo++;
            if (n == 5) wdata = 32'h1234_5678;
            @(posedge clk); #1;
        end
        tests_run++; if (acks2 !== 1) begin tests_failed++; $display("FAIL held_acks2: got %0d expected 1", acks2); end
        tests_run++; if (acks0 !== 1) begin tests_failed++; $display("FAIL held_acks0: got %0d expected 1", acks0); end
        tests_run++; if (busy_lo !== 0) begin tests_failed++; $display("FAIL held_busy: got %0d low samples expected 0", busy_lo); end
        req = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (bus2.busy !== 1'b0 || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL held_release: got busy %b/%b expected 0/0", bus2.busy, bus0.busy); end
        txn(1'b0, 32'h0000_0009, 32'h0);
        tests_run++; if (rd2 !== 32'hAAAA_5555 || rd0 !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL held_once: got %h/%h expected aaaa5555", rd2, rd0); end
    endtask

    task automatic test_rdata_hold();
        txn(1'b1, 32'h0000_000A, 32'h0BAD_F00D);
        tests_run++; if (bus2.rdata !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL rdata_hold2: got %h expected aaaa5555", bus2.rdata); end
        tests_run++; if (bus0.rdata !== 32'hAAAA_5555) begin tests_failed++; $display("FAIL rdata_hold0: got %h expected aaaa5555", bus0.rdata); end
    endtask

    task automatic test_range();
        logic [31:0] exp1;
        logic [31:0] exp10;
        txn(1'b1, 32'h0000_0001, 32'h4444_4444);
        txn(1'b1, 32'h0000_0000, 32'h5555_5555);
        txn(1'b1, 32'h7FFF_FFF1, 32'h3333_3333);
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
        tests_run++; if (err2 !== 1'b1 || err0 !== 1'b1) begin tests_failed++; $display("FAIL oor_wr_err: got %b/%b expected 1/1", err2, err0); end
`endif
        exp1  = ERR_BUILD ? 32'h4444_4444 : 32'h3333_3333;
        exp10 = ERR_BUILD ? 32'hDEAD_BEEF : 32'h5555_5555;
        txn(1'b0, 32'h0000_0001, 32'h0);
        tests_run++; if (rd2 !== exp1 || rd0 !== exp1) begin tests_failed++; $display("FAIL oor_mem1: got %h/%h expected %h", rd2, rd0, exp1); end
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
        tests_run++; if (err2 !== 1'b0) begin tests_failed++; $display("FAIL inrange_err: got %b expected 0", err2); end
`endif
        txn(1'b0, 32'h0000_0010, 32'h0);
        tests_run++; if (rd2 !== exp10 || rd0 !== exp10) begin tests_failed++; $display("FAIL oor_rd: got %h/%h expected %h", rd2, rd0, exp10); end
`ifdef CROSSBAR_SLAVE_MEM_ERR_EN
        tests_run++; if (err2 !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_err: got %b expected 1", err2); end
        tests_run++; if (bus2.err !== 1'b0) begin tests_failed++; $display("FAIL err_after: got %b expected 0", bus2.err); end
`endif
    endtask

    task automatic test_reset_mid_op();
        req = 1'b1; cmd = 1'b1; addr = 32'h0000_0007; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        tests_run++; if (bus2.busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_pre: got %b expected 1", bus2.busy); end
        rst = 1'b1;
        #1;
        tests_run++; if (bus2.ack !== 1'b0 || bus2.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst2: got ack=%b busy=%b expected 0/0", bus2.ack, bus2.busy); end
        tests_run++; if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL mid_rst0: got ack=%b busy=%b expected 0/0", bus0.ack, bus0.busy); end
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 32'h0000_0007, 32'h0);
        tests_run++; if (rd2 !== 32'h0 || rd0 !== 32'h0) begin tests_failed++; $display("FAIL mid_mem7: got %h/%h expected 00000000", rd2, rd0); end
        txn(1'b0, 32'h0000_0003, 32'h0);
        tests_run++; if (rd2 !== 32'h0 || rd0 !== 32'h0) begin tests_failed++; $display("FAIL mid_mem3: got %h/%h expected 00000000", rd2, rd0); end
        tests_run++; if (lat2 !== 3 || lat0 !== 1) begin tests_failed++; $display("FAIL mid_lat: got %0d/%0d expected 3/1", lat2, lat0); end
    endtask

    initial begin
        test_reset();
        test_latency0();
        test_write_read();
        test_slave_select();
        test_held_req();
        test_rdata_hold();
        test_range();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_crossbar_slave_mem
